clock_div_update_sequencer: RTL and testbench

Sequencer for the clock divider hard-macro slice. It accepts divider-ratio updates (mfi/mfn/mfd) and run/stop requests from the clock control logic. It drives the slice's asynchronous four-phase enable and update handshakes so that a ratio only changes while the divider output is stopped. It sits between the divider control logic and the divider hard macro, in the same clock domain as the control logic.

---
 rtl/clock_div_update_sequencer_pkg.sv | 19 +
 rtl/clock_div_update_sequencer_if.sv | 38 +++
 rtl/clock_div_update_sequencer_sync.sv | 23 ++
 rtl/clock_div_update_sequencer.sv | 168 ++++++++++++++++
 tb/tb_clock_div_update_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_div_update_sequencer_pkg.sv
// Shared state encoding and reset ratio for the clock divider update sequencer.
package clock_div_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EN_ON,
      ST_EN_OFF,
      ST_STOP,
      ST_UPD_REQ,
      ST_UPD_REL,
      ST_RESTORE,
      ST_FAULT
   } seq_state_t;

   localparam int unsigned RST_MFI = 1;
   localparam int unsigned RST_MFN = 0;
   localparam int unsigned RST_MFD = 1;

endpackage

// File: rtl/clock_div_update_sequencer_if.sv
// Signal bundle between divider control logic, the update sequencer and the divider hard macro.
// slave is the sequencer view; master is the control/macro side view.
interface clock_div_update_sequencer_if #(
   parameter int unsigned RATIO_W = 8
);
   logic               enable_request;
   logic               enabled;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [RATIO_W-1:0] cfg_mfi;
   logic [RATIO_W-1:0] cfg_mfn;
   logic [RATIO_W-1:0] cfg_mfd;
   logic               cfg_reject;
   logic               busy;
   logic               error;
   logic               async_enable;
   logic               async_enable_ack;
   logic               async_update;
   logic               async_update_ack;
   logic [RATIO_W-1:0] mfi;
   logic [RATIO_W-1:0] mfn;
   logic [RATIO_W-1:0] mfd;

   modport slave (
      input  enable_request, cfg_valid, cfg_mfi, cfg_mfn, cfg_mfd,
             async_enable_ack, async_update_ack,
      output enabled, cfg_ready, cfg_reject, busy, error,
             async_enable, async_update, mfi, mfn, mfd
   );

   modport master (
      output enable_request, cfg_valid, cfg_mfi, cfg_mfn, cfg_mfd,
             async_enable_ack, async_update_ack,
      input  enabled, cfg_ready, cfg_reject, busy, error,
             async_enable, async_update, mfi, mfn, mfd
   );

endinterface

// File: rtl/clock_div_update_sequencer_sync.sv
// Multi-flop synchronizer for an asynchronous acknowledge; SYNC_STAGES must be at least 2.
module clock_sync_ff #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic async_resetn,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clock or negedge async_resetn) begin
      if (!async_resetn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clock_div_update_sequencer.sv
// Sequences divider ratio loads so mfi/mfn/mfd only change while the divider output is stopped.
// Optional ack-wait timeout with FAULT recovery: define CLOCK_DIV_UPDATE_TIMEOUT_EN.
module clock_div_update_sequencer
   import clock_div_pkg::*;
#(
   parameter int unsigned RATIO_W        = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                          clock,
   input  logic                          async_resetn,
   clock_div_update_sequencer_if.slave   io_seq
);

   seq_state_t         r_state;
   logic               r_async_enable;
   logic               r_async_update;
   logic               r_cfg_reject;
   logic [RATIO_W-1:0] r_mfi;
   logic [RATIO_W-1:0] r_mfn;
   logic [RATIO_W-1:0] r_mfd;

   logic               w_en_ack_s;
   logic               w_up_ack_s;
   logic               w_advance;
   logic               w_wait;

   clock_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_en_ack_sync (
      .clock        (clock),
      .async_resetn (async_resetn),
      .i_async      (io_seq.async_enable_ack),
      .o_sync       (w_en_ack_s)
   );

   clock_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_up_ack_sync (
      .clock        (clock),
      .async_resetn (async_resetn),
      .i_async      (io_seq.async_update_ack),
      .o_sync       (w_up_ack_s)
   );

   // The synced ack matches what the current state is waiting for.
   always_comb begin
      w_advance = 1'b0;
      case (r_state)
         ST_EN_ON:            w_advance = w_en_ack_s;
         ST_EN_OFF, ST_STOP:  w_advance = !w_en_ack_s;
         ST_UPD_REQ:          w_advance = w_up_ack_s;
         ST_UPD_REL:          w_advance = !w_up_ack_s;
         ST_RESTORE:          w_advance = (w_en_ack_s == r_async_enable);
         ST_FAULT:            w_advance = !w_en_ack_s && !w_up_ack_s;
         default:             w_advance = 1'b0;
      endcase
   end

   assign w_wait = (r_state != ST_IDLE) && (r_state != ST_FAULT);

`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_error;
   logic             w_timeout;

   assign w_timeout = w_wait && !w_advance && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clock or negedge async_resetn) begin
      if (!async_resetn) begin
         r_state        <= ST_IDLE;
         r_async_enable <= 1'b0;
         r_async_update <= 1'b0;
         r_cfg_reject   <= 1'b0;
         r_mfi          <= RATIO_W'(RST_MFI);
         r_mfn          <= RATIO_W'(RST_MFN);
         r_mfd          <= RATIO_W'(RST_MFD);
`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
         r_wait_cnt     <= '0;
         r_error        <= 1'b0;
`endif
      end else begin
         r_cfg_reject <= 1'b0;
`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
         if (!w_wait || w_advance) begin
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
`endif
         case (r_state)
            ST_IDLE: begin
               // A ratio offer wins over a pending run/stop change in the same cycle.
               if (io_seq.cfg_valid) begin
                  if (io_seq.cfg_mfd == '0) begin
                     r_cfg_reject <= 1'b1;
                  end else begin
                     r_mfi <= io_seq.cfg_mfi;
                     r_mfn <= io_seq.cfg_mfn;
                     r_mfd <= io_seq.cfg_mfd;
`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
                     r_error <= 1'b0;
`endif
                     if (r_async_enable) begin
                        r_async_enable <= 1'b0;
                        r_state        <= ST_STOP;
                     end else begin
                        r_async_update <= 1'b1;
                        r_state        <= ST_UPD_REQ;
                     end
                  end
               end else if (io_seq.enable_request && !r_async_enable) begin
                  r_async_enable <= 1'b1;
                  r_state        <= ST_EN_ON;
               end else if (!io_seq.enable_request && r_async_enable) begin
                  r_async_enable <= 1'b0;
                  r_state        <= ST_EN_OFF;
               end
            end
            ST_EN_ON, ST_EN_OFF, ST_RESTORE, ST_FAULT: begin
               if (w_advance) r_state <= ST_IDLE;
            end
            ST_STOP: begin
               if (w_advance) begin
                  r_async_update <= 1'b1;
                  r_state        <= ST_UPD_REQ;
               end
            end
            ST_UPD_REQ: begin
               if (w_advance) begin
                  r_async_update <= 1'b0;
                  r_state        <= ST_UPD_REL;
               end
            end
            ST_UPD_REL: begin
               // Run state is re-sampled here so a stop request made mid-update is honoured.
               if (w_advance) begin
                  r_async_enable <= io_seq.enable_request;
                  r_state        <= ST_RESTORE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
         if (w_timeout) begin
            r_error        <= 1'b1;
            r_async_enable <= 1'b0;
            r_async_update <= 1'b0;
            r_state        <= ST_FAULT;
         end
`endif
      end
   end

   assign io_seq.async_enable = r_async_enable;
   assign io_seq.async_update = r_async_update;
   assign io_seq.cfg_reject   = r_cfg_reject;
   assign io_seq.cfg_ready    = (r_state == ST_IDLE);
   assign io_seq.busy         = (r_state != ST_IDLE);
   assign io_seq.enabled      = (r_state == ST_IDLE) && r_async_enable && w_en_ack_s;
   assign io_seq.mfi          = r_mfi;
   assign io_seq.mfn          = r_mfn;
   assign io_seq.mfd          = r_mfd;
`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
   assign io_seq.error        = r_error;
`else
   assign io_seq.error        = 1'b0;
`endif

endmodule

// File: tb/tb_clock_div_update_sequencer.sv
// Scoreboard bench for clock_div_update_sequencer with a loop-back hard macro model.
module tb_clock_div_update_sequencer;

   localparam int unsigned RATIO_W = 8;

   logic clock        = 1'b0;
   logic async_resetn = 1'b0;

   clock_div_update_sequencer_if #(.RATIO_W(RATIO_W)) io_seq ();

   clock_div_update_sequencer #(
      .RATIO_W        (RATIO_W),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (16)
   ) u_dut (
      .clock        (clock),
      .async_resetn (async_resetn),
      .io_seq       (io_seq.slave)
   );

   always #5 clock = ~clock;

   // Hard macro model: acks follow requests instantly or one clock late; update ack can stick low.
   logic ack_dly    = 1'b1;
   logic up_stuck   = 1'b0;
   logic r_en_ack_d = 1'b0;
   logic r_up_ack_d = 1'b0;

   always @(posedge clock) begin
      r_en_ack_d <= io_seq.async_enable;
      r_up_ack_d <= io_seq.async_update;
   end

   assign io_seq.async_enable_ack = ack_dly ? r_en_ack_d : io_seq.async_enable;
   assign io_seq.async_update_ack = up_stuck ? 1'b0 : (ack_dly ? r_up_ack_d : io_seq.async_update);

   typedef struct packed {
      logic         rej;
      logic [7:0]   mfi;
      logic [7:0]   mfn;
      logic [7:0]   mfd;
      logic         en;
   } exp_t;

   exp_t sb_q[$];
   int   ev_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic expect_op(input logic rej, input logic [7:0] i, input logic [7:0] f,
                            input logic [7:0] d, input logic en);
      exp_t e;
      e.rej = rej;
      e.mfi = i;
      e.mfn = f;
      e.mfd = d;
      e.en  = en;
      sb_q.push_back(e);
   endtask

   // Monitor: logs request edges, watches ratio stability, pops the scoreboard on completion.
   logic        prev_busy   = 1'b0;
   logic        prev_rej    = 1'b0;
   logic        prev_en     = 1'b0;
   logic        prev_up     = 1'b0;
   logic [23:0] prev_ratio  = '0;
   logic        ratio_moved = 1'b0;
   exp_t        mon_e;

   always @(negedge clock) begin
      if (async_resetn) begin
         if (io_seq.async_enable != prev_en) ev_q.push_back(io_seq.async_enable ? 1 : 2);
         if (io_seq.async_update != prev_up) ev_q.push_back(io_seq.async_update ? 3 : 4);
         if (prev_up && io_seq.async_update &&
             ({io_seq.mfi, io_seq.mfn, io_seq.mfd} != prev_ratio)) ratio_moved = 1'b1;
         if ((prev_busy && !io_seq.busy) || (io_seq.cfg_reject && !prev_rej)) begin
            if (sb_q.size() == 0) begin
               check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("sb_reject", 32'(io_seq.cfg_reject), 32'(mon_e.rej));
               check_val("sb_mfi", 32'(io_seq.mfi), 32'(mon_e.mfi));
               check_val("sb_mfn", 32'(io_seq.mfn), 32'(mon_e.mfn));
               check_val("sb_mfd", 32'(io_seq.mfd), 32'(mon_e.mfd));
               if (!mon_e.rej) check_val("sb_enabled", 32'(io_seq.enabled), 32'(mon_e.en));
            end
         end
      end
      prev_busy  = io_seq.busy;
      prev_rej   = io_seq.cfg_reject;
      prev_en    = io_seq.async_enable;
      prev_up    = io_seq.async_update;
      prev_ratio = {io_seq.mfi, io_seq.mfn, io_seq.mfd};
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (io_seq.busy && n < 200) begin
         tick();
         n++;
      end
      if (io_seq.busy) check_val("idle_timeout", 32'(io_seq.busy), 32'd0);
   endtask

   task automatic send_cfg(input logic [7:0] i, input logic [7:0] f, input logic [7:0] d);
      io_seq.cfg_valid = 1'b1;
      io_seq.cfg_mfi   = i;
      io_seq.cfg_mfn   = f;
      io_seq.cfg_mfd   = d;
      tick();
      io_seq.cfg_valid = 1'b0;
   endtask

   function automatic logic [31:0] ev_code();
      logic [31:0] c;
      c = '0;
      foreach (ev_q[k]) c = (c << 4) | 32'(ev_q[k]);
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      io_seq.enable_request = 1'b0;
      io_seq.cfg_valid      = 1'b0;
      io_seq.cfg_mfi        = '0;
      io_seq.cfg_mfn        = '0;
      io_seq.cfg_mfd        = '0;

      repeat (3) @(posedge clock);
      #1;
      check_val("rst_mfi", 32'(io_seq.mfi), 32'd1);
      check_val("rst_mfn", 32'(io_seq.mfn), 32'd0);
      check_val("rst_mfd", 32'(io_seq.mfd), 32'd1);
      check_val("rst_async_enable", 32'(io_seq.async_enable), 32'd0);
      check_val("rst_async_update", 32'(io_seq.async_update), 32'd0);
      check_val("rst_error", 32'(io_seq.error), 32'd0);
      check_val("rst_cfg_reject", 32'(io_seq.cfg_reject), 32'd0);
      check_val("rst_busy", 32'(io_seq.busy), 32'd0);
      check_val("rst_enabled", 32'(io_seq.enabled), 32'd0);
      check_val("rst_cfg_ready", 32'(io_seq.cfg_ready), 32'd1);
      async_resetn = 1'b1;
      tick();
      tick();

      // Enable with one-cycle-late ack loop-back.
      ack_dly = 1'b1;
      expect_op(1'b0, 8'd1, 8'd0, 8'd1, 1'b1);
      io_seq.enable_request = 1'b1;
      tick();
      check_val("en_on_async_enable", 32'(io_seq.async_enable), 32'd1);
      check_val("en_on_busy", 32'(io_seq.busy), 32'd1);
      wait_idle(n);
      check_val("en_on_cycles", 32'(1 + n), 32'd5);
      check_val("en_on_enabled", 32'(io_seq.enabled), 32'd1);

      // Ratio update while running.
      ev_q.delete();
      ratio_moved = 1'b0;
      check_val("run_cfg_ready", 32'(io_seq.cfg_ready), 32'd1);
      expect_op(1'b0, 8'd4, 8'd1, 8'd3, 1'b1);
      send_cfg(8'd4, 8'd1, 8'd3);
      check_val("run_busy", 32'(io_seq.busy), 32'd1);
      check_val("run_cfg_ready_low", 32'(io_seq.cfg_ready), 32'd0);
      check_val("run_en_fall", 32'(io_seq.async_enable), 32'd0);
      check_val("run_mfi", 32'(io_seq.mfi), 32'd4);
      wait_idle(n);
      check_val("run_seq", ev_code(), 32'h2341);
      check_val("run_ratio_stable", 32'(ratio_moved), 32'd0);
      check_val("run_enabled", 32'(io_seq.enabled), 32'd1);

      // Stop the divider, then update with instant ack loop-back.
      expect_op(1'b0, 8'd4, 8'd1, 8'd3, 1'b0);
      io_seq.enable_request = 1'b0;
      tick();
      wait_idle(n);
      check_val("stop_enabled", 32'(io_seq.enabled), 32'd0);
      ack_dly = 1'b0;
      ev_q.delete();
      expect_op(1'b0, 8'd7, 8'd2, 8'd5, 1'b0);
      send_cfg(8'd7, 8'd2, 8'd5);
      wait_idle(n);
      check_val("stopped_cycles", 32'(1 + n), 32'd8);
      check_val("stopped_seq", ev_code(), 32'h34);
      check_val("stopped_async_enable", 32'(io_seq.async_enable), 32'd0);

      // Illegal ratio is discarded.
      ev_q.delete();
      expect_op(1'b1, 8'd7, 8'd2, 8'd5, 1'b0);
      send_cfg(8'd9, 8'd9, 8'd0);
      check_val("rej_pulse", 32'(io_seq.cfg_reject), 32'd1);
      check_val("rej_busy", 32'(io_seq.busy), 32'd0);
      check_val("rej_mfd", 32'(io_seq.mfd), 32'd5);
      check_val("rej_mfi", 32'(io_seq.mfi), 32'd7);
      tick();
      check_val("rej_pulse_end", 32'(io_seq.cfg_reject), 32'd0);
      check_val("rej_no_toggle", 32'(ev_q.size()), 32'd0);

      // Run request dropped during UPD_REQ.
      ack_dly = 1'b1;
      expect_op(1'b0, 8'd7, 8'd2, 8'd5, 1'b1);
      io_seq.enable_request = 1'b1;
      tick();
      wait_idle(n);
      expect_op(1'b0, 8'd3, 8'd3, 8'd3, 1'b0);
      send_cfg(8'd3, 8'd3, 8'd3);
      n = 0;
      while (!io_seq.async_update && n < 50) begin
         tick();
         n++;
      end
      check_val("drop_upd_req_seen", 32'(io_seq.async_update), 32'd1);
      io_seq.enable_request = 1'b0;
      wait_idle(n);
      check_val("drop_async_enable", 32'(io_seq.async_enable), 32'd0);
      check_val("drop_enabled", 32'(io_seq.enabled), 32'd0);
      check_val("drop_mfi", 32'(io_seq.mfi), 32'd3);

`ifdef CLOCK_DIV_UPDATE_TIMEOUT_EN
      // Update ack never returns.
      up_stuck = 1'b1;
      expect_op(1'b0, 8'd5, 8'd5, 8'd5, 1'b0);
      send_cfg(8'd5, 8'd5, 8'd5);
      n = 0;
      while (!io_seq.error && n < 100) begin
         tick();
         n++;
      end
      check_val("to_cycles", 32'(n), 32'd16);
      check_val("to_async_update", 32'(io_seq.async_update), 32'd0);
      check_val("to_busy", 32'(io_seq.busy), 32'd1);
      check_val("to_cfg_ready", 32'(io_seq.cfg_ready), 32'd0);
      wait_idle(n);
      check_val("to_error_sticky", 32'(io_seq.error), 32'd1);
      up_stuck = 1'b0;
      expect_op(1'b0, 8'd6, 8'd6, 8'd6, 1'b0);
      send_cfg(8'd6, 8'd6, 8'd6);
      check_val("to_error_clear", 32'(io_seq.error), 32'd0);
      wait_idle(n);
      check_val("to_mfi", 32'(io_seq.mfi), 32'd6);
`else
      check_val("error_tied", 32'(io_seq.error), 32'd0);
`endif

      tick();
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
